// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit for the MIPS32 EX stage.
//
// Owns the HI/LO architectural registers. Multiply runs for a fixed MUL_LAT
// cycles; divide is a restoring divider producing one quotient bit per cycle,
// followed by one sign-fix cycle (W+1 busy cycles in total).
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (op codes 6-9). Without it those codes are ignored like any unknown op.
//
// Handshake: an op is accepted on a rising edge where start=1, busy=0 and
// cancel=0. busy is high from the cycle after acceptance until the HI/LO
// write edge; done pulses for one cycle right after that write edge, and a
// new op may be accepted in that same cycle. cancel drops any in-flight op
// without touching HI/LO. MTHI/MTLO complete at the accept edge (no busy).
//
// Ports:
//   clk     in   clock, rising-edge
//   rst     in   synchronous reset, active-high
//   start   in   op request
//   mdu_op  in   op code (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,
//                6 MADD,7 MADDU,8 MSUB,9 MSUBU)
//   op1     in   rs operand
//   op2     in   rt operand
//   cancel  in   abort in-flight op
//   busy    out  op in flight
//   done    out  one-cycle completion pulse for MUL/DIV-class ops
//   hi, lo  out  HI/LO registers
// -----------------------------------------------------------------------------
module mdu #(
    parameter int W       = 32,
    parameter int MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   mdu_op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    // Counter must reach W (sign-fix cycle) and MUL_LAT-1.
    localparam int CMAX = (W > MUL_LAT) ? W : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   rem, quo;

    logic accept;
    logic in_mul, in_div, in_mthi, in_mtlo;
    logic mul_last, div_last, wr_mul, wr_div;

    // ---------------- request decode ----------------
    always_comb begin
        in_mul  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
        in_mul  = in_mul || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU) ||
                  (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU);
`endif
        in_div  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
        in_mthi = (mdu_op == OP_MTHI);
        in_mtlo = (mdu_op == OP_MTLO);
    end

    assign busy   = (state != IDLE);
    assign accept = start && !busy && !cancel;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_last   = 1'b0;
        div_last   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && in_mul)      state_next = MUL;
                else if (accept && in_div) state_next = DIV;
            end
            MUL: begin
                if (cnt == CW'(MUL_LAT - 1)) begin
                    mul_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (cnt == CW'(W)) begin
                    div_last   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (cancel) state_next = IDLE;
    end

    // A cancel on the write edge suppresses the write.
    assign wr_mul = mul_last && !cancel;
    assign wr_div = div_last && !cancel;

    // ---------------- latched-op decode ----------------
    logic q_mul_signed, q_acc, q_sub, q_div_signed;
    always_comb begin
        q_mul_signed = (op_q == OP_MULT);
        q_acc        = 1'b0;
        q_sub        = 1'b0;
`ifdef MDU_MADD_EN
        q_mul_signed = q_mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
        q_acc        = (op_q == OP_MADD) || (op_q == OP_MADDU);
        q_sub        = (op_q == OP_MSUB) || (op_q == OP_MSUBU);
`endif
        q_div_signed = (op_q == OP_DIV);
    end

    // ---------------- multiply / accumulate ----------------
    // Operands are extended to 2W so a plain multiply gives the correct
    // product modulo 2^(2W) for both signed and unsigned forms.
    logic [2*W-1:0] ext_a, ext_b, prod;
    logic [2*W:0]   hilo_ext, acc;
    always_comb begin
        ext_a    = q_mul_signed ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
        ext_b    = q_mul_signed ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
        prod     = ext_a * ext_b;
        hilo_ext = {1'b0, hi, lo};
        if (q_sub)      acc = hilo_ext - {1'b0, prod};
        else if (q_acc) acc = hilo_ext + {1'b0, prod};
        else            acc = {1'b0, prod};
    end

    // ---------------- divide ----------------
    logic [W-1:0] b_abs, q_fix, r_fix;
    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         q_neg, r_neg;
    always_comb begin
        b_abs   = (q_div_signed && b_q[W-1]) ? (~b_q + 1'b1) : b_q;
        shifted = {rem, quo[W-1]};
        // One extra bit so the borrow is visible even when shifted >= 2^W.
        trial   = {1'b0, shifted} - {2'b00, b_abs};
        q_neg   = q_div_signed && (a_q[W-1] ^ b_q[W-1]);
        r_neg   = q_div_signed && a_q[W-1];
        q_fix   = q_neg ? (~quo + 1'b1) : quo;
        r_fix   = r_neg ? (~rem + 1'b1) : rem;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rem  <= '0;
            quo  <= '0;
        end else begin
            done <= wr_mul || wr_div;

            if (state == IDLE || state_next == IDLE) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;

            if (accept) begin
                op_q <= mdu_op;
                a_q  <= op1;
                b_q  <= op2;
                if (in_mthi) hi <= op1;
                if (in_mtlo) lo <= op1;
                if (in_div) begin
                    rem <= '0;
                    quo <= ((mdu_op == OP_DIV) && op1[W-1]) ? (~op1 + 1'b1) : op1;
                end
            end

            // Restoring iteration: magnitudes only, signs applied at the end.
            if (state == DIV && cnt < CW'(W)) begin
                if (!trial[W+1]) begin
                    rem <= trial[W-1:0];
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= shifted[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
            end

            if (wr_mul) {hi, lo} <= acc[2*W-1:0];

            if (wr_div) begin
                if (b_q == '0) begin
                    lo <= '1;
                    hi <= a_q;
                end else begin
                    lo <= q_fix;
                    hi <= r_fix;
                end
            end
        end
    end

endmodule
